// File: rtl/axi4_lite_master.sv
// AXI4-Lite master bridge: turns level store/load requests from the memory stage into
// AXI4-Lite write/read transactions, with independent write and read state machines.
module axi4_lite_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    write_start,
    input  logic [ADDR_WIDTH-1:0]   write_addr,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] write_strobe,
    output logic                    write_busy,
    output logic                    write_err,

    input  logic                    read_start,
    input  logic [ADDR_WIDTH-1:0]   read_addr,
    output logic [DATA_WIDTH-1:0]   read_data,
    output logic                    read_busy,
    output logic                    read_err,

    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [2:0]              m_awprot,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,

    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic [2:0]              m_arprot,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rvalid,
    output logic                    m_rready
);

    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP, W_DONE} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA, R_DONE} r_state_t;

    w_state_t w_state;
    r_state_t r_state;

    logic aw_hs;
    logic w_hs;
    logic aw_clear;
    logic w_clear;

    assign m_awprot = 3'b000;
    assign m_arprot = 3'b000;

    assign aw_hs = m_awvalid & m_awready;
    assign w_hs  = m_wvalid & m_wready;

    // A channel is finished once its valid is already down or handshakes this cycle,
    // so AW and W may complete in either order or together.
    assign aw_clear = !m_awvalid || m_awready;
    assign w_clear  = !m_wvalid || m_wready;

    // Combinational so the stall appears in the very cycle the request is raised.
    assign write_busy = ((w_state == W_IDLE) && write_start) ||
                        (w_state == W_REQ) || (w_state == W_RESP);
    assign read_busy  = ((r_state == R_IDLE) && read_start) ||
                        (r_state == R_ADDR) || (r_state == R_DATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state   <= W_IDLE;
            m_awaddr  <= '0;
            m_wdata   <= '0;
            m_wstrb   <= '0;
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            m_bready  <= 1'b0;
            write_err <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    write_err <= 1'b0;
                    if (write_start) begin
                        m_awaddr  <= write_addr;
                        m_wdata   <= write_data;
                        m_wstrb   <= write_strobe;
                        m_awvalid <= 1'b1;
                        m_wvalid  <= 1'b1;
                        w_state   <= W_REQ;
                    end
                end
                W_REQ: begin
                    if (aw_hs) m_awvalid <= 1'b0;
                    if (w_hs)  m_wvalid  <= 1'b0;
                    if (aw_clear && w_clear) begin
                        m_bready <= 1'b1;
                        w_state  <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (m_bvalid) begin
                        m_bready  <= 1'b0;
                        write_err <= (m_bresp != 2'b00);
                        w_state   <= W_DONE;
                    end
                end
                W_DONE: begin
                    // One non-busy cycle; a held write_start is ignored here.
                    write_err <= 1'b0;
                    w_state   <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= R_IDLE;
            m_araddr  <= '0;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b0;
            read_data <= '0;
            read_err  <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    read_err <= 1'b0;
                    if (read_start) begin
                        m_araddr  <= read_addr;
                        m_arvalid <= 1'b1;
                        r_state   <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        r_state   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (m_rvalid) begin
                        m_rready  <= 1'b0;
                        read_data <= m_rdata;
                        read_err  <= (m_rresp != 2'b00);
                        r_state   <= R_DONE;
                    end
                end
                R_DONE: begin
                    // read_data keeps the captured word until the next capture.
                    read_err <= 1'b0;
                    r_state  <= R_IDLE;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_master.sv
// Scoreboard bench for axi4_lite_master: directed stores/loads against a small slave model;
// a monitor checks AXI handshakes and completions against queued expectations.
module tb_axi4_lite_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_start;
    logic [31:0] write_addr;
    logic [31:0] write_data;
    logic [3:0]  write_strobe;
    logic        write_busy;
    logic        write_err;
    logic        read_start;
    logic [31:0] read_addr;
    logic [31:0] read_data;
    logic        read_busy;
    logic        read_err;
    logic [31:0] m_awaddr;
    logic [2:0]  m_awprot;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic [31:0] m_araddr;
    logic [2:0]  m_arprot;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;

    axi4_lite_master dut (
        .clk(clk), .rst(rst),
        .write_start(write_start), .write_addr(write_addr), .write_data(write_data),
        .write_strobe(write_strobe), .write_busy(write_busy), .write_err(write_err),
        .read_start(read_start), .read_addr(read_addr), .read_data(read_data),
        .read_busy(read_busy), .read_err(read_err),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave configuration, owned by the stimulus process.
    int          b_delay    = 0;
    int          r_delay    = 0;
    logic [1:0]  b_resp_cfg = 2'b00;
    logic [1:0]  r_resp_cfg = 2'b00;
    logic [31:0] rdata_cfg  = 32'h0;

    // Scoreboard queues.
    logic [31:0] exp_aw[$];
    logic [35:0] exp_w[$];
    logic        exp_werr[$];
    logic [31:0] exp_ar[$];
    logic [32:0] exp_r[$];
    int          aw_hs_cyc[$];

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: handshake with no queued expectation (cycle %0d)", name, cyc);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Slave model: readies come from the stimulus; B/R responses follow a handshake after
    // b_delay/r_delay extra cycles and hold until accepted.
    initial begin
        bit   aw_got;
        bit   w_got;
        int   b_wait;
        int   r_wait;
        logic nb;
        logic nr;
        aw_got = 0; w_got = 0; b_wait = -1; r_wait = -1; nb = 0; nr = 0;
        m_bvalid = 0; m_bresp = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                aw_got = 0; w_got = 0; b_wait = -1; r_wait = -1; nb = 0; nr = 0;
            end else begin
                nb = m_bvalid;
                if (m_bvalid && m_bready) nb = 0;
                if (m_awvalid && m_awready) aw_got = 1;
                if (m_wvalid && m_wready) w_got = 1;
                if (b_wait > 0) b_wait--;
                else if (b_wait == 0) begin nb = 1; b_wait = -1; end
                if (aw_got && w_got) begin
                    aw_got = 0; w_got = 0;
                    if (b_delay == 0) nb = 1; else b_wait = b_delay - 1;
                end
                nr = m_rvalid;
                if (m_rvalid && m_rready) nr = 0;
                if (r_wait > 0) r_wait--;
                else if (r_wait == 0) begin nr = 1; r_wait = -1; end
                if (m_arvalid && m_arready) begin
                    if (r_delay == 0) nr = 1; else r_wait = r_delay - 1;
                end
            end
            @(posedge clk);
            #1;
            m_bvalid = nb;
            m_bresp  = nb ? b_resp_cfg : 2'b00;
            m_rvalid = nr;
            m_rdata  = nr ? rdata_cfg : 32'h0;
            m_rresp  = nr ? r_resp_cfg : 2'b00;
        end
    end

    // Monitor: pops expectations on each handshake and on each completion cycle.
    initial begin
        bit b_pend;
        bit b_post;
        bit r_pend;
        bit r_post;
        logic [32:0] er;
        b_pend = 0; b_post = 0; r_pend = 0; r_post = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_aw.delete(); exp_w.delete(); exp_werr.delete();
                exp_ar.delete(); exp_r.delete();
                b_pend = 0; b_post = 0; r_pend = 0; r_post = 0;
            end else begin
                if (b_post) begin
                    chk("write_err_after_done", write_err, 0);
                    b_post = 0;
                end
                if (b_pend) begin
                    if (exp_werr.size() == 0) unexpected("b_resp");
                    else chk("write_err_in_done", write_err, exp_werr.pop_front());
                    chk("write_busy_in_done", write_busy, 0);
                    b_pend = 0;
                    b_post = 1;
                end
                if (r_post) begin
                    chk("read_err_after_done", read_err, 0);
                    r_post = 0;
                end
                if (r_pend) begin
                    if (exp_r.size() == 0) unexpected("r_resp");
                    else begin
                        er = exp_r.pop_front();
                        chk("read_data_in_done", read_data, er[31:0]);
                        chk("read_err_in_done", read_err, er[32]);
                    end
                    chk("read_busy_in_done", read_busy, 0);
                    r_pend = 0;
                    r_post = 1;
                end
                if (m_awvalid && m_awready) begin
                    aw_hs_cyc.push_back(cyc);
                    if (exp_aw.size() == 0) unexpected("aw");
                    else chk("awaddr", m_awaddr, exp_aw.pop_front());
                    chk("awprot", m_awprot, 0);
                end
                if (m_wvalid && m_wready) begin
                    if (exp_w.size() == 0) unexpected("w");
                    else chk("wstrb_wdata", {m_wstrb, m_wdata}, exp_w.pop_front());
                end
                if (m_arvalid && m_arready) begin
                    if (exp_ar.size() == 0) unexpected("ar");
                    else chk("araddr", m_araddr, exp_ar.pop_front());
                    chk("arprot", m_arprot, 0);
                end
                if (m_bvalid && m_bready) b_pend = 1;
                if (m_rvalid && m_rready) r_pend = 1;
            end
        end
    end

    task automatic push_write(input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic err);
        exp_aw.push_back(a);
        exp_w.push_back({s, d});
        exp_werr.push_back(err);
    endtask

    task automatic push_read(input logic [31:0] a, input logic [31:0] d, input logic err);
        exp_ar.push_back(a);
        exp_r.push_back({err, d});
    endtask

    initial begin
        rst = 1; write_start = 0; write_addr = 0; write_data = 0; write_strobe = 0;
        read_start = 0; read_addr = 0;
        m_awready = 1; m_wready = 1; m_arready = 1;

        // Reset state
        tick; tick;
        @(negedge clk);
        chk("rst_valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
        chk("rst_busy", {write_busy, read_busy}, 0);
        chk("rst_err", {write_err, read_err}, 0);
        chk("rst_read_data", read_data, 0);
        chk("rst_awaddr", m_awaddr, 0);
        chk("rst_wdata", m_wdata, 0);
        chk("rst_wstrb", m_wstrb, 0);
        chk("rst_araddr", m_araddr, 0);
        tick; rst = 0;
        tick;

        // Zero-wait store
        tick;
        write_addr = 32'h10; write_data = 32'hDEADBEEF; write_strobe = 4'hF; write_start = 1;
        push_write(32'h10, 32'hDEADBEEF, 4'hF, 0);
        @(negedge clk);
        chk("t1_c0_busy", write_busy, 1);
        chk("t1_c0_awvalid", m_awvalid, 0);
        tick; write_start = 0;
        @(negedge clk);
        chk("t1_c1_valids", {m_awvalid, m_wvalid}, 2'b11);
        chk("t1_c1_busy", write_busy, 1);
        tick;
        @(negedge clk);
        chk("t1_c2_valids", {m_awvalid, m_wvalid}, 2'b00);
        chk("t1_c2_busy_bready", {write_busy, m_bready}, 2'b11);
        tick;
        @(negedge clk);
        chk("t1_c3_busy", write_busy, 0);
        chk("t1_c3_err", write_err, 0);
        tick;

        // AW backpressure
        tick;
        m_awready = 0;
        write_addr = 32'h14; write_data = 32'hCAFEF00D; write_strobe = 4'b0011; write_start = 1;
        push_write(32'h14, 32'hCAFEF00D, 4'b0011, 0);
        tick; write_start = 0;
        @(negedge clk);
        chk("t2_c1_valids", {m_awvalid, m_wvalid}, 2'b11);
        for (int c = 2; c <= 4; c++) begin
            tick;
            if (c == 4) m_awready = 1;
            @(negedge clk);
            chk("t2_wvalid_dropped", m_wvalid, 0);
            chk("t2_awvalid_held", m_awvalid, 1);
            chk("t2_awaddr_held", m_awaddr, 32'h14);
            chk("t2_busy", write_busy, 1);
        end
        tick;
        @(negedge clk);
        chk("t2_c5_awvalid", m_awvalid, 0);
        chk("t2_c5_busy", write_busy, 1);
        tick;
        @(negedge clk);
        chk("t2_c6_done", write_busy, 0);
        tick;

        // Load with rvalid delayed two cycles
        tick;
        r_delay = 2; rdata_cfg = 32'h12345678; r_resp_cfg = 2'b00;
        read_addr = 32'h20; read_start = 1;
        push_read(32'h20, 32'h12345678, 0);
        @(negedge clk);
        chk("t3_c0_busy", read_busy, 1);
        tick; read_start = 0;
        @(negedge clk);
        chk("t3_c1_arvalid", m_arvalid, 1);
        tick;
        @(negedge clk);
        chk("t3_c2_arvalid_rready", {m_arvalid, m_rready}, 2'b01);
        for (int c = 3; c <= 4; c++) begin
            tick;
            @(negedge clk);
            chk("t3_busy_wait", read_busy, 1);
        end
        tick;
        @(negedge clk);
        chk("t3_c5_busy", read_busy, 0);
        chk("t3_c5_data", read_data, 32'h12345678);
        repeat (10) tick;
        @(negedge clk);
        chk("t3_data_held", read_data, 32'h12345678);

        // Error responses
        tick;
        r_delay = 0; b_resp_cfg = 2'b10;
        write_addr = 32'h18; write_data = 32'h1; write_strobe = 4'h1; write_start = 1;
        push_write(32'h18, 32'h1, 4'h1, 1);
        tick; write_start = 0;
        tick;
        @(negedge clk);
        chk("t4_werr_early", write_err, 0);
        tick;
        @(negedge clk);
        chk("t4_werr_done", write_err, 1);
        tick;
        @(negedge clk);
        chk("t4_werr_late", write_err, 0);
        b_resp_cfg = 2'b00;
        tick;
        r_resp_cfg = 2'b11; rdata_cfg = 32'hA5A50F0F;
        read_addr = 32'h24; read_start = 1;
        push_read(32'h24, 32'hA5A50F0F, 1);
        tick; read_start = 0;
        tick;
        @(negedge clk);
        chk("t4_rerr_early", read_err, 0);
        tick;
        @(negedge clk);
        chk("t4_rerr_done", read_err, 1);
        tick;
        @(negedge clk);
        chk("t4_rerr_late", read_err, 0);
        r_resp_cfg = 2'b00;

        // Held write_start across two stores
        tick;
        aw_hs_cyc.delete();
        write_addr = 32'h30; write_data = 32'h11111111; write_strobe = 4'hF; write_start = 1;
        push_write(32'h30, 32'h11111111, 4'hF, 0);
        push_write(32'h34, 32'h22222222, 4'hF, 0);
        tick; tick;
        tick;
        write_addr = 32'h34; write_data = 32'h22222222;
        @(negedge clk);
        chk("t5_c3_done_gap", write_busy, 0);
        tick;
        @(negedge clk);
        chk("t5_c4_relaunch_busy", write_busy, 1);
        chk("t5_c4_awvalid", m_awvalid, 0);
        tick;
        @(negedge clk);
        chk("t5_c5_awvalid", m_awvalid, 1);
        tick;
        tick; write_start = 0;
        @(negedge clk);
        chk("t5_c7_done", write_busy, 0);
        tick;
        @(negedge clk);
        chk("t5_idle", {m_awvalid, write_busy}, 0);
        chk("t5_aw_count", aw_hs_cyc.size(), 2);
        if (aw_hs_cyc.size() == 2) chk("t5_aw_spacing", aw_hs_cyc[1] - aw_hs_cyc[0], 4);

        // Concurrent store and load
        tick;
        r_delay = 1; rdata_cfg = 32'h0BADF00D;
        write_addr = 32'h40; write_data = 32'h55AA55AA; write_strobe = 4'hC; write_start = 1;
        read_addr = 32'h44; read_start = 1;
        push_write(32'h40, 32'h55AA55AA, 4'hC, 0);
        push_read(32'h44, 32'h0BADF00D, 0);
        @(negedge clk);
        chk("t6_c0_busy", {write_busy, read_busy}, 2'b11);
        tick; write_start = 0; read_start = 0;
        @(negedge clk);
        chk("t6_c1_valids", {m_awvalid, m_wvalid, m_arvalid}, 3'b111);
        tick; tick;
        @(negedge clk);
        chk("t6_c3_busy", {write_busy, read_busy}, 2'b01);
        tick;
        @(negedge clk);
        chk("t6_c4_busy", {write_busy, read_busy}, 2'b00);
        chk("t6_c4_data", read_data, 32'h0BADF00D);

        // Reset while write waits in W_RESP and read waits in R_ADDR
        tick;
        b_delay = 3; m_arready = 0;
        write_addr = 32'h50; write_data = 32'h77; write_strobe = 4'hF; write_start = 1;
        read_addr = 32'h54; read_start = 1;
        push_write(32'h50, 32'h77, 4'hF, 0);
        push_read(32'h54, 32'h0, 0);
        tick; write_start = 0; read_start = 0;
        tick; rst = 1;
        @(negedge clk);
        chk("t7_pre_states", {m_bready, m_arvalid}, 2'b11);
        tick; rst = 0; b_delay = 0; m_arready = 1;
        @(negedge clk);
        chk("t7_valids_readies", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 0);
        chk("t7_busy", {write_busy, read_busy}, 0);
        chk("t7_read_data", read_data, 0);
        chk("t7_awaddr", m_awaddr, 0);
        tick; tick;
        @(negedge clk);
        chk("queues_empty", exp_aw.size() + exp_w.size() + exp_werr.size() +
                            exp_ar.size() + exp_r.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi4_lite_master.md
# axi4_lite_master

AXI4-Lite master bridge between the memory stage and the peripheral interconnect. It turns the memory stage's level-sensitive store and load requests into AXI4-Lite write and read transactions. While a transaction is in flight it asserts busy, which stalls the pipeline. It captures read data and response status and returns them to the memory stage. The write and read channels run as independent state machines and may be active at the same time.

## Interface
- ADDR_WIDTH, 32, address width of all address ports.
- DATA_WIDTH, 32, data width (fixed at 32; the strobe is 4 bits).
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- write_start  in  1  level store request from the memory stage.
- write_addr  in  32  store byte address.
- write_data  in  32  store data, unshifted.
- write_strobe  in  4  byte enables.
- write_busy  out  1  stall request for the write channel.
- write_err  out  1  one-cycle pulse when BRESP is not OKAY.
- read_start  in  1  level load request.
- read_addr  in  32  load byte address.
- read_data  out  32  captured RDATA, a full word.
- read_busy  out  1  stall request for the read channel.
- read_err  out  1  one-cycle pulse when RRESP is not OKAY.
- AXI write ports: m_awaddr out 32, m_awprot out 3, m_awvalid out 1, m_awready in 1, m_wdata out 32, m_wstrb out 4, m_wvalid out 1, m_wready in 1, m_bresp in 2, m_bvalid in 1, m_bready out 1.
- AXI read ports: m_araddr out 32, m_arprot out 3, m_arvalid out 1, m_arready in 1, m_rdata in 32, m_rresp in 2, m_rvalid in 1, m_rready out 1.

## Operation
- Write FSM states: W_IDLE, W_REQ, W_RESP, W_DONE.
  - W_IDLE with write_start=1: latch addr, data and strobe into m_aw*/m_w*; set m_awvalid=m_wvalid=1; go to W_REQ.
  - W_REQ: each valid clears independently on its own handshake (valid & ready). When both handshakes are complete (including both in the same cycle), go to W_RESP.
  - W_RESP: m_bready=1. On m_bvalid, register write_err=(m_bresp!=2'b00) and go to W_DONE.
  - W_DONE: write_err is high for this cycle only; go to W_IDLE unconditionally. write_start is not sampled in W_DONE.
- Read FSM states: R_IDLE, R_ADDR, R_DATA, R_DONE.
  - R_IDLE with read_start=1: latch m_araddr, set m_arvalid=1, go to R_ADDR.
  - R_ADDR: on m_arready, clear m_arvalid and go to R_DATA.
  - R_DATA: m_rready=1. On m_rvalid, register read_data=m_rdata and read_err=(m_rresp!=2'b00); go to R_DONE.
  - R_DONE: go to R_IDLE.
- busy equations (combinational, so the stall appears in the same cycle the request does):
  - write_busy = (W_IDLE & write_start) | W_REQ | W_RESP.
  - read_busy likewise, using the read states and read_start.
- The DONE state provides exactly one non-busy cycle in which the pipeline advances. This prevents a held start from relaunching the same access.
- Simultaneous write_start and read_start: both channels launch, and each busy clears on its own completion.
- AXI stability: address, data and strobe registers hold while their valid is high. No valid deasserts before its handshake.
- m_awprot and m_arprot are tied to 3'b000.
- read_data holds its value until the next R_DATA capture. Byte/half selection and extension stay in the memory stage.

## Timing
- Reset values: both FSMs IDLE; all m_*valid, m_bready and m_rready 0; m_awaddr, m_wdata, m_araddr and read_data 0; m_wstrb 0; write_err and read_err 0. Both busy outputs are 0 while start is low.
- Reset mid-transaction: at the next edge all valids drop and both FSMs go to IDLE. No response is awaited; reset is system-wide.
- Zero-wait slave (ready=1, response one cycle after handshake), write:
  - c0: W_IDLE, write_busy=1.
  - c1: valids high, handshake.
  - c2: bvalid.
  - c3: W_DONE, write_busy=0.
  - Three stall cycles.
- Read, same slave:
  - c1: arvalid.
  - c2: rvalid captured.
  - c3: R_DONE, read_data valid, read_busy=0.
- Each slave wait cycle on any channel adds one busy cycle.

## Test plan
- Store to 0x10, data 0xDEADBEEF, strobe 4'b1111, zero-wait slave:
  - m_awvalid/m_wvalid high in c1 only.
  - write_busy high c0–c2, low c3.
  - write_err stays 0.
- AW backpressure: m_wready=1, m_awready low for 3 cycles then high:
  - m_wvalid drops after c1.
  - m_awvalid and m_awaddr hold stable through c4.
  - W_DONE in c6.
- Load from 0x20 with rvalid delayed 2 cycles, rdata 0x12345678:
  - read_data=0x12345678 in R_DONE.
  - read_data still 0x12345678 ten cycles later with no further loads.
- Error responses:
  - bresp=2'b10: write_err pulses for exactly one cycle, in W_DONE.
  - rresp=2'b11: read_err pulses for exactly one cycle, in R_DONE.
- Held start with back-to-back accesses:
  - write_start held high across two consecutive stores: exactly two AW handshakes, with a one-cycle gap (W_DONE) between them.
  - Concurrent read_start and write_start: both channels complete independently.
- rst asserted in W_RESP and R_ADDR:
  - Next cycle: all valids and readies 0, both busy 0 with starts low, read_data=0.
